// File: rtl/mix_columns_ctrl_if.sv
// Signal bundle between mix_columns_ctrl and its environment.
// The last_round input exists only when MIXCOL_LAST_ROUND_EN is defined.
interface mix_columns_ctrl_if;
    logic         start;
    logic [127:0] state_in;
    logic [7:0]   mc_result;
`ifdef MIXCOL_LAST_ROUND_EN
    logic         last_round;
`endif
    logic [1:0]   mc_row;
    logic [7:0]   mc_col0;
    logic [7:0]   mc_col1;
    logic [7:0]   mc_col2;
    logic [7:0]   mc_col3;
    logic [127:0] state_out;
    logic         busy;
    logic         done;

    modport slave (
`ifdef MIXCOL_LAST_ROUND_EN
        input  last_round,
`endif
        input  start, state_in, mc_result,
        output mc_row, mc_col0, mc_col1, mc_col2, mc_col3, state_out, busy, done
    );

    modport master (
`ifdef MIXCOL_LAST_ROUND_EN
        output last_round,
`endif
        output start, state_in, mc_result,
        input  mc_row, mc_col0, mc_col1, mc_col2, mc_col3, state_out, busy, done
    );
endinterface

// File: rtl/mix_columns_ctrl.sv
// Sequences one AES MixColumns pass through an external byte-wide mixColumns unit, one byte per cycle.
// MIXCOL_LAST_ROUND_EN adds a last_round input that bypasses the pass (state_in copied to state_out).
module mix_columns_ctrl (
    input  logic             clk,
    input  logic             rst_n,
    mix_columns_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] buf_q, buf_d;
    logic [127:0] out_q, out_d;
    logic [1:0]   row_q, row_d;
    logic [7:0]   col_q [4];
    logic [7:0]   col_d [4];
    logic         last_round;

`ifdef MIXCOL_LAST_ROUND_EN
    assign last_round = bus.last_round;
`else
    assign last_round = 1'b0;
`endif

    // Byte k lives at bits 127-8k downto 120-8k; 15-k is simply ~k for a 4-bit index.
    function automatic logic [7:0] byte_of(input logic [127:0] s, input logic [3:0] k);
        return s[{~k, 3'b000} +: 8];
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        out_d   = out_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    buf_d = bus.state_in;
                    cnt_d = 4'd0;
                    row_d = 2'd0;
                    for (int r = 0; r < 4; r++)
                        col_d[r] = byte_of(bus.state_in, {2'b00, 2'(r)});
                    if (last_round) begin
                        out_d   = bus.state_in;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                out_d[{~cnt_q, 3'b000} +: 8] = bus.mc_result;
                cnt_d = cnt_q + 4'd1;
                // Pre-load the unit's operands for the next byte so they come straight from flops.
                row_d = cnt_d[1:0];
                for (int r = 0; r < 4; r++)
                    col_d[r] = byte_of(buf_q, {cnt_d[3:2], 2'(r)});
                if (cnt_q == 4'd15)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            buf_q   <= '0;
            out_q   <= '0;
            row_q   <= 2'd0;
            for (int r = 0; r < 4; r++)
                col_q[r] <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign bus.mc_row    = row_q;
    assign bus.mc_col0   = col_q[0];
    assign bus.mc_col1   = col_q[1];
    assign bus.mc_col2   = col_q[2];
    assign bus.mc_col3   = col_q[3];
    assign bus.state_out = out_q;
    // Status is forced low while reset is held, even before the reset edge lands.
    assign bus.busy      = rst_n && (state_q != IDLE);
    assign bus.done      = rst_n && (state_q == DONE);
endmodule

// File: doc/mix_columns_ctrl.md
MIX_COLUMNS_CTRL -- requirements
Module: mix_columns_ctrl

Interface
REQ-001 The block SHALL have no parameters; the state width is fixed at 128 bits (16 bytes), and byte k sits at state[127-8k -: 8].
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to run one MixColumns pass on state_in.
REQ-005 state_in  input  128  input state, column-major: byte k = row (k mod 4), column (k div 4).
REQ-006 mc_result  input  8  combinational result byte returned by the mixColumns unit.
REQ-007 mc_row  output  2  row select driven to the mixColumns unit.
REQ-008 mc_col0..mc_col3  output  8 each  current column bytes (rows 0..3) driven to the mixColumns unit.
REQ-009 state_out  output  128  result state, same byte ordering as state_in.
REQ-010 busy  output  1  high while a pass is in progress.
REQ-011 done  output  1  one-cycle pulse: state_out is complete.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE; only these transitions are legal: IDLE->RUN on start, RUN->DONE after byte 15, DONE->IDLE unconditionally.
REQ-013 In IDLE with start=1, the block SHALL latch state_in into an internal buffer, clear the 4-bit counter cnt to 0 and enter RUN at that edge.
REQ-014 In RUN, mc_row SHALL equal cnt[1:0] and mc_colr SHALL equal buffered byte 4*cnt[3:2]+r; all of these are driven from registers only.
REQ-015 In RUN, each edge SHALL write mc_result into state_out byte cnt and increment cnt, so one byte is produced per cycle for 16 cycles.
REQ-016 The edge that writes byte 15 SHALL enter DONE; cnt wraps to 0 and is not used further.
REQ-017 done SHALL be 1 only in DONE, i.e. on the 17th cycle after the start edge; busy SHALL be 1 in RUN and DONE.
REQ-018 start SHALL be ignored in RUN and DONE; a start in DONE is not queued, and only a start seen in IDLE is accepted.
REQ-019 state_out SHALL hold its value from DONE until the next accepted start; bytes then update one by one during RUN.
REQ-020 state_in changes after the start edge SHALL NOT affect the pass in progress.
REQ-021 Back-to-back passes SHALL be possible: start is held high and re-accepted in the cycle after DONE, giving an 18-cycle period.

Reset
REQ-022 With rst_n=0 at an edge, the block SHALL go to IDLE, and cnt, the buffer, state_out, mc_row and mc_col0..3 SHALL all become 0.
REQ-023 While rst_n=0, busy and done SHALL be 0.
REQ-024 Reset during RUN or DONE SHALL abort the pass with no done pulse; a start seen in the same cycle as reset is ignored.

Configuration
REQ-025 Macro MIXCOL_LAST_ROUND_EN SHALL add input last_round (1 bit), sampled together with start.
REQ-026 With MIXCOL_LAST_ROUND_EN defined, a start accepted with last_round=1 SHALL copy state_in directly into state_out and enter DONE at that edge, skipping RUN; done is then asserted 1 cycle after the start edge.
REQ-027 With MIXCOL_LAST_ROUND_EN undefined, the last_round port SHALL not exist and every pass SHALL take the RUN path.

Verification
REQ-028 Reset with rst_n=0 for 2 cycles -> state_out=0, busy=0, done=0, mc_row=0.
REQ-029 A start with state_in columns db135345/f20a225c/01010101/c6c6c6c6, mixColumns attached -> done on cycle 17 with state_out=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
REQ-030 A start pulse during RUN, and state_in changed mid-pass -> result unchanged from REQ-029, with exactly one done pulse.
REQ-031 start held high for 40 cycles -> done pulses at cycles 17 and 35, and busy drops for exactly one cycle between the passes.
REQ-032 rst_n=0 at cycle 8 of RUN -> no done pulse, state_out=0, block in IDLE, and the next start completes normally.
REQ-033 With MIXCOL_LAST_ROUND_EN defined, a start with last_round=1 and state_in=00112233445566778899aabbccddeeff -> done on the next cycle with state_out equal to state_in.
